// File: rtl/bus_pkg.sv
// Shared types for the 3-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GNT2 = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd3;
  localparam int NUM_MASTERS = 3;

  function automatic logic [1:0] state_to_id(input state_t s);
    return (s == IDLE) ? GRANT_NONE : (2'(s) - 2'd1);
  endfunction

  function automatic state_t id_to_state(input logic [1:0] id);
    return state_t'(id + 2'd1);
  endfunction

  function automatic logic [2:0] id_to_oh(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/bus_arb_pick3.sv
// Combinational 3-way priority picker; search begins at start and wraps.
module bus_arb_pick3
  import bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  output logic [1:0] idx,
  output logic       valid
);

  function automatic logic [1:0] wrap3(input logic [1:0] s, input int k);
    int v;
    v = (int'(s) + k) % NUM_MASTERS;
    return 2'(v);
  endfunction

  always_comb begin
    idx   = GRANT_NONE;
    valid = 1'b0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[wrap3(start, k)]) begin
        idx   = wrap3(start, k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_3.sv
// 3-master bus arbiter: fixed priority with bounded hold and idle turnaround.
// Define BUS_ARB_ROUND_ROBIN_EN for rotating priority in IDLE.
module bus_arbiter_3
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] grant_id,
  output logic       bus_busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]       mask, mask_nxt;
  logic [2:0]       req, eff_req, own_oh;
  logic [1:0]       own, start;
  logic [1:0]       eff_idx, raw_idx;
  logic             eff_vld, raw_vld;

  assign req     = {m2_req, m1_req, m0_req};
  assign eff_req = req & ~mask;
  assign own     = state_to_id(state);
  assign own_oh  = id_to_oh(own);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner;

  assign start = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_owner <= 2'd2;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_owner <= state_to_id(state_nxt);
    end
  end
`else
  assign start = 2'd0;
`endif

  bus_arb_pick3 u_pick_eff (
    .req   (eff_req),
    .start (start),
    .idx   (eff_idx),
    .valid (eff_vld)
  );

  // Fallback when only the masked master is asking.
  bus_arb_pick3 u_pick_raw (
    .req   (req),
    .start (start),
    .idx   (raw_idx),
    .valid (raw_vld)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    mask_nxt  = mask;
    unique case (state)
      IDLE: begin
        hold_nxt = '0;
        if (eff_vld) begin
          state_nxt = id_to_state(eff_idx);
          mask_nxt  = '0;
        end else if (raw_vld) begin
          state_nxt = id_to_state(raw_idx);
          mask_nxt  = '0;
        end
      end
      default: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
        if ((req & own_oh) == 3'b000) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST &&
                     (req & ~own_oh) != 3'b000) begin
          state_nxt = IDLE;
          mask_nxt  = mask | own_oh;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      mask     <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      mask     <= mask_nxt;
    end
  end

  assign m0_grant = (state == GNT0);
  assign m1_grant = (state == GNT1);
  assign m2_grant = (state == GNT2);
  assign grant_id = own;
  assign bus_busy = (state != IDLE);

endmodule
